// File: rtl/irq_ack_sequencer_if.sv
// CPU-side vector handshake between the interrupt sequencer and its consumer.
// The master presents {bus, chan} with irq_valid; the slave accepts with irq_ready.
interface irq_ack_sequencer_if;
  localparam int unsigned VEC_W = 6;

  logic             irq_valid;
  logic [VEC_W-1:0] irq_vec;
  logic             irq_ready;

  modport master (
    output irq_valid,
    output irq_vec,
    input  irq_ready
  );

  modport slave (
    input  irq_valid,
    input  irq_vec,
    output irq_ready
  );
endinterface

// File: rtl/irq_ack_sequencer.sv
// Captures interrupt request pulses into pending bits and latches the resolver winner.
// It presents the winner to the CPU, then clears it and acks the source on acceptance.
module irq_ack_sequencer (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8:0]              req_a_i,
  input  logic [8:0]              req_b_i,
  input  logic [8:0]              req_c_i,
  input  logic                    en_i,
  output logic [8:0]              pend_a_o,
  output logic [8:0]              pend_b_o,
  output logic [8:0]              pend_c_o,
  input  logic                    pa_i,
  input  logic                    pb_i,
  input  logic                    pc_i,
  input  logic [3:0]              chan_i,
  irq_ack_sequencer_if.master     cpu,
  output logic [8:0]              ack_a_o,
  output logic [8:0]              ack_b_o,
  output logic [8:0]              ack_c_o,
  output logic                    err_o
);
  localparam int unsigned NCH    = 9;
  localparam int unsigned CHAN_W = 4;
  localparam int unsigned BUS_W  = 2;
  localparam int unsigned VEC_W  = BUS_W + CHAN_W;

  localparam logic [BUS_W-1:0]  BUS_A    = 2'd0;
  localparam logic [BUS_W-1:0]  BUS_B    = 2'd1;
  localparam logic [BUS_W-1:0]  BUS_C    = 2'd2;
  localparam logic [CHAN_W-1:0] CHAN_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRES = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NCH-1:0]     pend_a_q, pend_a_d;
  logic [NCH-1:0]     pend_b_q, pend_b_d;
  logic [NCH-1:0]     pend_c_q, pend_c_d;
  logic [NCH-1:0]     ack_a_q, ack_a_d;
  logic [NCH-1:0]     ack_b_q, ack_b_d;
  logic [NCH-1:0]     ack_c_q, ack_c_d;
  logic               valid_q, valid_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               err_q, err_d;

  logic [1:0]         flag_cnt;
  logic               code_illegal;
  logic [BUS_W-1:0]   win_bus;
  logic [NCH-1:0]     chan_mask;
  logic [NCH-1:0]     clr_a, clr_b, clr_c;

  // Resolver code qualification and winner bus encoding.
  always_comb begin
    flag_cnt     = 2'(pa_i) + 2'(pb_i) + 2'(pc_i);
    code_illegal = (flag_cnt > 2'd1) || (chan_i > CHAN_MAX);
    if (pa_i) begin
      win_bus = BUS_A;
    end else if (pb_i) begin
      win_bus = BUS_B;
    end else begin
      win_bus = BUS_C;
    end
    chan_mask = NCH'(1) << vec_q[CHAN_W-1:0];
  end

  // Next-state, clear mask and registered-output next values.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    vec_d    = vec_q;
    err_d    = err_q;
    clr_a    = '0;
    clr_b    = '0;
    clr_c    = '0;

    case (state_q)
      IDLE: begin
        if (en_i) begin
          if (code_illegal) begin
            err_d = 1'b1;
          end else if (flag_cnt == 2'd1) begin
            vec_d   = {win_bus, chan_i};
            valid_d = 1'b1;
            state_d = PRES;
          end
        end
      end
      PRES: begin
        if (cpu.irq_ready) begin
          case (vec_q[VEC_W-1:CHAN_W])
            BUS_A:   clr_a = chan_mask;
            BUS_B:   clr_b = chan_mask;
            default: clr_c = chan_mask;
          endcase
          valid_d = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A request arriving on the clearing edge keeps its bit set.
    pend_a_d = (pend_a_q & ~clr_a) | req_a_i;
    pend_b_d = (pend_b_q & ~clr_b) | req_b_i;
    pend_c_d = (pend_c_q & ~clr_c) | req_c_i;
    ack_a_d  = clr_a;
    ack_b_d  = clr_b;
    ack_c_d  = clr_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_a_q <= '0;
      pend_b_q <= '0;
      pend_c_q <= '0;
      ack_a_q  <= '0;
      ack_b_q  <= '0;
      ack_c_q  <= '0;
      valid_q  <= 1'b0;
      vec_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      pend_c_q <= pend_c_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      ack_c_q  <= ack_c_d;
      valid_q  <= valid_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
    end
  end

  assign pend_a_o      = pend_a_q;
  assign pend_b_o      = pend_b_q;
  assign pend_c_o      = pend_c_q;
  assign ack_a_o       = ack_a_q;
  assign ack_b_o       = ack_b_q;
  assign ack_c_o       = ack_c_q;
  assign err_o         = err_q;
  assign cpu.irq_valid = valid_q;
  assign cpu.irq_vec   = vec_q;
endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Directed bench for irq_ack_sequencer with a behavioural priority resolver on pend_*.
`timescale 1ns/1ps
module tb_irq_ack_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] req_a, req_b, req_c;
  logic       en;
  logic [8:0] pend_a, pend_b, pend_c;
  logic       pa, pb, pc;
  logic [3:0] chan;
  logic [8:0] ack_a, ack_b, ack_c;
  logic       err;

  logic       ovr, ovr_pa, ovr_pb, ovr_pc;
  logic [3:0] ovr_chan;

  int checks = 0;
  int errors = 0;

  irq_ack_sequencer_if cpu_if ();

  irq_ack_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a_i  (req_a),
    .req_b_i  (req_b),
    .req_c_i  (req_c),
    .en_i     (en),
    .pend_a_o (pend_a),
    .pend_b_o (pend_b),
    .pend_c_o (pend_c),
    .pa_i     (pa),
    .pb_i     (pb),
    .pc_i     (pc),
    .chan_i   (chan),
    .cpu      (cpu_if),
    .ack_a_o  (ack_a),
    .ack_b_o  (ack_b),
    .ack_c_o  (ack_c),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] low_idx(input logic [8:0] v);
    low_idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) low_idx = 4'(i);
    end
  endfunction

  // Resolver model: bus A > B > C, lowest line index within the bus.
  always_comb begin
    pa = 1'b0; pb = 1'b0; pc = 1'b0; chan = 4'd0;
    if (|pend_a) begin
      pa = 1'b1; chan = low_idx(pend_a);
    end else if (|pend_b) begin
      pb = 1'b1; chan = low_idx(pend_b);
    end else if (|pend_c) begin
      pc = 1'b1; chan = low_idx(pend_c);
    end
    if (ovr) begin
      pa = ovr_pa; pb = ovr_pb; pc = ovr_pc; chan = ovr_chan;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b0 || cpu_if.irq_vec !== 6'd0) begin
      errors++; $display("FAIL reset_vec valid=%b vec=%h exp 0/00", cpu_if.irq_valid, cpu_if.irq_vec);
    end
    checks++;
    if ({pend_a, pend_b, pend_c} !== 27'd0 || {ack_a, ack_b, ack_c} !== 27'd0) begin
      errors++; $display("FAIL reset_pend_ack pend=%h ack=%h exp 0", {pend_c, pend_b, pend_a}, {ack_c, ack_b, ack_a});
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b exp 0", err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_b = 9'h020;
    tick();
    req_b = 9'h000;
    checks++;
    if (pend_b !== 9'h020 || cpu_if.irq_valid !== 1'b0) begin
      errors++; $display("FAIL single_pend pend_b=%h valid=%b exp 020/0", pend_b, cpu_if.irq_valid);
    end
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== 6'b01_0101) begin
      errors++; $display("FAIL single_vec valid=%b vec=%b exp 1/010101", cpu_if.irq_valid, cpu_if.irq_vec);
    end
    cpu_if.irq_ready = 1'b1;
    tick();
    cpu_if.irq_ready = 1'b0;
    checks++;
    if (ack_b !== 9'b000100000 || ack_a !== 9'h0 || ack_c !== 9'h0 || pend_b !== 9'h0 || cpu_if.irq_valid !== 1'b0) begin
      errors++; $display("FAIL single_ack ack_b=%b pend_b=%h valid=%b exp 000100000/000/0", ack_b, pend_b, cpu_if.irq_valid);
    end
    tick();
    checks++;
    if (ack_b !== 9'h0 || cpu_if.irq_valid !== 1'b0) begin
      errors++; $display("FAIL single_ack_drop ack_b=%b valid=%b exp 0/0", ack_b, cpu_if.irq_valid);
    end
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b0 || cpu_if.irq_vec !== 6'b01_0101) begin
      errors++; $display("FAIL single_idle_hold valid=%b vec=%b exp 0/010101", cpu_if.irq_valid, cpu_if.irq_vec);
    end
  endtask

  task automatic test_drain();
    logic [5:0]  exp_vec [3];
    logic [26:0] exp_ack [3];
    exp_vec[0] = 6'h03; exp_ack[0] = {9'h000, 9'h000, 9'h008};
    exp_vec[1] = 6'h18; exp_ack[1] = {9'h000, 9'h100, 9'h000};
    exp_vec[2] = 6'h20; exp_ack[2] = {9'h001, 9'h000, 9'h000};
    cpu_if.irq_ready = 1'b1;
    req_a = 9'h008; req_b = 9'h100; req_c = 9'h001;
    tick();
    req_a = 9'h000; req_b = 9'h000; req_c = 9'h000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== exp_vec[i]) begin
        errors++; $display("FAIL drain_vec%0d valid=%b vec=%h exp 1/%h", i, cpu_if.irq_valid, cpu_if.irq_vec, exp_vec[i]);
      end
      tick();
      checks++;
      if (cpu_if.irq_valid !== 1'b0 || {ack_c, ack_b, ack_a} !== exp_ack[i]) begin
        errors++; $display("FAIL drain_ack%0d valid=%b ack=%h exp 0/%h", i, cpu_if.irq_valid, {ack_c, ack_b, ack_a}, exp_ack[i]);
      end
      tick();
      checks++;
      if (cpu_if.irq_valid !== 1'b0 || {ack_c, ack_b, ack_a} !== 27'd0) begin
        errors++; $display("FAIL drain_gap%0d valid=%b ack=%h exp 0/0", i, cpu_if.irq_valid, {ack_c, ack_b, ack_a});
      end
    end
    cpu_if.irq_ready = 1'b0;
    checks++;
    if ({pend_c, pend_b, pend_a} !== 27'd0) begin
      errors++; $display("FAIL drain_empty pend=%h exp 0", {pend_c, pend_b, pend_a});
    end
  endtask

  task automatic test_backpressure();
    int bad;
    req_b = 9'h004;
    tick();
    req_b = 9'h000;
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== 6'h12) begin
      errors++; $display("FAIL bp_first valid=%b vec=%h exp 1/12", cpu_if.irq_valid, cpu_if.irq_vec);
    end
    req_a = 9'h001;
    tick();
    req_a = 9'h000;
    en = 1'b0;
    checks++;
    if (pend_a !== 9'h001 || cpu_if.irq_vec !== 6'h12) begin
      errors++; $display("FAIL bp_pend pend_a=%h vec=%h exp 001/12", pend_a, cpu_if.irq_vec);
    end
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== 6'h12 || {ack_c, ack_b, ack_a} !== 27'd0) bad++;
    end
    en = 1'b1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold bad_cycles=%0d exp 0 (vec=%h)", bad, cpu_if.irq_vec);
    end
    cpu_if.irq_ready = 1'b1;
    tick();
    checks++;
    if (ack_b !== 9'h004 || pend_b !== 9'h000 || pend_a !== 9'h001) begin
      errors++; $display("FAIL bp_ack ack_b=%h pend_b=%h pend_a=%h exp 004/000/001", ack_b, pend_b, pend_a);
    end
    tick();
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== 6'h00) begin
      errors++; $display("FAIL bp_next valid=%b vec=%h exp 1/00", cpu_if.irq_valid, cpu_if.irq_vec);
    end
    tick();
    checks++;
    if (ack_a !== 9'h001 || pend_a !== 9'h000) begin
      errors++; $display("FAIL bp_next_ack ack_a=%h pend_a=%h exp 001/000", ack_a, pend_a);
    end
    cpu_if.irq_ready = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    en = 1'b0;
    req_a = 9'h002;
    tick();
    req_a = 9'h000;
    tick();
    tick();
    checks++;
    if (pend_a !== 9'h002 || cpu_if.irq_valid !== 1'b0) begin
      errors++; $display("FAIL en_low pend_a=%h valid=%b exp 002/0", pend_a, cpu_if.irq_valid);
    end
    en = 1'b1;
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== 6'h01) begin
      errors++; $display("FAIL en_high valid=%b vec=%h exp 1/01", cpu_if.irq_valid, cpu_if.irq_vec);
    end
    cpu_if.irq_ready = 1'b1;
    tick();
    tick();
    cpu_if.irq_ready = 1'b0;
  endtask

  task automatic test_collision();
    req_c = 9'h004;
    tick();
    req_c = 9'h000;
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== 6'h22) begin
      errors++; $display("FAIL coll_vec valid=%b vec=%h exp 1/22", cpu_if.irq_valid, cpu_if.irq_vec);
    end
    cpu_if.irq_ready = 1'b1;
    req_c = 9'h004;
    tick();
    req_c = 9'h000;
    checks++;
    if (pend_c !== 9'h004 || ack_c !== 9'h004 || cpu_if.irq_valid !== 1'b0) begin
      errors++; $display("FAIL coll_setwins pend_c=%h ack_c=%h valid=%b exp 004/004/0", pend_c, ack_c, cpu_if.irq_valid);
    end
    tick();
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== 6'h22) begin
      errors++; $display("FAIL coll_repres valid=%b vec=%h exp 1/22", cpu_if.irq_valid, cpu_if.irq_vec);
    end
    tick();
    checks++;
    if (pend_c !== 9'h000 || ack_c !== 9'h004) begin
      errors++; $display("FAIL coll_final pend_c=%h ack_c=%h exp 000/004", pend_c, ack_c);
    end
    cpu_if.irq_ready = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    ovr = 1'b1; ovr_pa = 1'b1; ovr_pb = 1'b1; ovr_pc = 1'b0; ovr_chan = 4'd3;
    tick();
    checks++;
    if (err !== 1'b1 || cpu_if.irq_valid !== 1'b0) begin
      errors++; $display("FAIL ill_multi err=%b valid=%b exp 1/0", err, cpu_if.irq_valid);
    end
    ovr = 1'b0;
    tick();
    tick();
    checks++;
    if (err !== 1'b1 || cpu_if.irq_valid !== 1'b0) begin
      errors++; $display("FAIL ill_sticky err=%b valid=%b exp 1/0", err, cpu_if.irq_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL ill_reset err=%b exp 0", err);
    end
    ovr = 1'b1; ovr_pa = 1'b1; ovr_pb = 1'b0; ovr_pc = 1'b0; ovr_chan = 4'd12;
    tick();
    ovr = 1'b0;
    checks++;
    if (err !== 1'b1 || cpu_if.irq_valid !== 1'b0) begin
      errors++; $display("FAIL ill_chan err=%b valid=%b exp 1/0", err, cpu_if.irq_valid);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL ill_chan_sticky err=%b exp 1", err);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    req_a = 9'h010; req_c = 9'h001;
    tick();
    req_a = 9'h000; req_c = 9'h000;
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vec !== 6'h04) begin
      errors++; $display("FAIL rmid_vec valid=%b vec=%h exp 1/04", cpu_if.irq_valid, cpu_if.irq_vec);
    end
    cpu_if.irq_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b0 || {ack_c, ack_b, ack_a} !== 27'd0 || {pend_c, pend_b, pend_a} !== 27'd0) begin
      errors++; $display("FAIL rmid_reset valid=%b ack=%h pend=%h exp 0/0/0", cpu_if.irq_valid, {ack_c, ack_b, ack_a}, {pend_c, pend_b, pend_a});
    end
    rst_n = 1'b1;
    cpu_if.irq_ready = 1'b0;
    tick();
    checks++;
    if (cpu_if.irq_valid !== 1'b0 || {ack_c, ack_b, ack_a} !== 27'd0 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_after valid=%b ack=%h err=%b exp 0/0/0", cpu_if.irq_valid, {ack_c, ack_b, ack_a}, err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    en = 1'b1;
    cpu_if.irq_ready = 1'b0;
    ovr = 1'b0; ovr_pa = 1'b0; ovr_pb = 1'b0; ovr_pc = 1'b0; ovr_chan = 4'd0;
    test_reset();
    test_single();
    test_drain();
    test_backpressure();
    test_enable();
    test_collision();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
